// File: rtl/iteration_frame_packer_if.sv
// Signal bundle between the iteration producer, the frame packer and the byte-wide UART.
// Byte handshake: a byte moves on every rising edge where tx_valid & tx_ready; tx_valid/tx_data hold until then.
interface iteration_frame_packer_if #(
   parameter int DATA_W = 102
);
   logic              data_availible;
   logic [DATA_W-1:0] sensor_iterations;
   logic              reset_parser;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              busy;

   modport master (
      input  data_availible, sensor_iterations, tx_ready,
      output reset_parser, tx_data, tx_valid, busy
   );

   modport slave (
      output data_availible, sensor_iterations, tx_ready,
      input  reset_parser, tx_data, tx_valid, busy
   );
endinterface

// File: rtl/iteration_frame_packer.sv
// Captures one iteration word, acknowledges it, and streams it as a framed byte sequence:
// SYNC0 SYNC1 seq payload(MSB first) chk, where chk is the XOR of seq and the payload bytes.
module iteration_frame_packer #(
   parameter int         DATA_W = 102,
   parameter logic [7:0] SYNC0  = 8'hA5,
   parameter logic [7:0] SYNC1  = 8'h5A
) (
   input  logic                           clk_12MHz,
   input  logic                           rst_n,
   iteration_frame_packer_if.master       bus,
   output logic [1:0]                     state_o
);
   localparam int NB    = (DATA_W + 7) / 8;
   localparam int L     = NB + 4;
   localparam int IDX_W = $clog2(L + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, SEND = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [NB*8-1:0]     shadow_q, shadow_d;
   logic [7:0]          seq_q, seq_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [7:0]          chk_q, chk_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                busy_q, busy_d;
   logic                rp_q, rp_d;

   logic [NB*8-1:0]     word_ext;
   logic                xfer;
   logic [IDX_W-1:0]    idx_nx;
   logic [7:0]          chk_fold;
   logic [7:0]          pay_byte;
   logic [7:0]          nx_byte;

   always_comb begin
      word_ext = '0;
      word_ext[DATA_W-1:0] = bus.sensor_iterations;
   end

   // Byte that follows the one currently on tx_data; the chk slot sees the fold of the last payload byte.
   always_comb begin
      xfer     = tx_valid_q & bus.tx_ready;
      idx_nx   = idx_q + 1'b1;
      chk_fold = chk_q;
      if (idx_q >= IDX_W'(2) && idx_q <= IDX_W'(L - 2))
         chk_fold = chk_q ^ tx_data_q;
      pay_byte = '0;
      for (int k = 0; k < NB; k++) begin
         if (idx_nx == IDX_W'(k + 3))
            pay_byte = shadow_q[8*(NB-1-k) +: 8];
      end
      if (idx_nx == IDX_W'(1))
         nx_byte = SYNC1;
      else if (idx_nx == IDX_W'(2))
         nx_byte = seq_q;
      else if (idx_nx == IDX_W'(L - 1))
         nx_byte = chk_fold;
      else
         nx_byte = pay_byte;
   end

   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      seq_d      = seq_q;
      idx_d      = idx_q;
      chk_d      = chk_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      busy_d     = busy_q;
      rp_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.data_availible) begin
               shadow_d   = word_ext;
               busy_d     = 1'b1;
               rp_d       = 1'b1;
               tx_valid_d = 1'b1;
               tx_data_d  = SYNC0;
               idx_d      = '0;
               chk_d      = '0;
               state_d    = ACK;
            end
         end
         ACK, SEND: begin
            if (state_q == ACK)
               state_d = SEND;
            if (xfer) begin
               chk_d = chk_fold;
               if (idx_q == IDX_W'(L - 1)) begin
                  tx_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  seq_d      = seq_q + 8'd1;
                  state_d    = IDLE;
               end else begin
                  idx_d     = idx_nx;
                  tx_data_d = nx_byte;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_12MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shadow_q   <= '0;
         seq_q      <= '0;
         idx_q      <= '0;
         chk_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         rp_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         seq_q      <= seq_d;
         idx_q      <= idx_d;
         chk_q      <= chk_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         rp_q       <= rp_d;
      end
   end

   assign bus.reset_parser = rp_q;
   assign bus.tx_data      = tx_data_q;
   assign bus.tx_valid     = tx_valid_q;
   assign bus.busy         = busy_q;
   assign state_o          = state_q;
endmodule
